// File: rtl/div2i2o_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : div2i2o_seq_if
//  Description : Handshake and operand/result bundle for the sequential
//                restoring divider. The master issues start/a/b and observes
//                busy/done/div_by_zero/quotient/remainder; the slave is the
//                divider itself.
//  Ports       : start, a, b                              (master -> slave)
//                busy, done, div_by_zero, quotient,
//                remainder                                (slave -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface div2i2o_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    modport master (
        output start, a, b,
        input  busy, done, div_by_zero, quotient, remainder
    );

    modport slave (
        input  start, a, b,
        output busy, done, div_by_zero, quotient, remainder
    );
endinterface
`default_nettype wire

// File: rtl/div2i2o_seq.sv
`default_nettype none
// ============================================================================
//  Module      : div2i2o_seq
//  Description : Unsigned radix-2 restoring divider, one quotient bit per
//                clock. start is honoured in IDLE or DONE; a nonzero divisor
//                runs WIDTH RUN cycles, a zero divisor completes at once with
//                quotient = all ones, remainder = a and div_by_zero set.
//                quotient/remainder only change on completion.
//  Ports       : clk    - rising-edge clock
//                clr_n  - asynchronous active-low reset
//                bus    - div2i2o_seq_if slave (start, a, b in;
//                         busy, done, div_by_zero, quotient, remainder out)
//  Revision    : 1.0 - initial release
// ============================================================================
module div2i2o_seq #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           clr_n,
    div2i2o_seq_if.slave   bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   prem_q;      // partial remainder
    logic [WIDTH-1:0]   shreg_q;     // dividend bits out at top, quotient bits in at bottom
    logic [WIDTH-1:0]   divisor_q;
    logic [WIDTH-1:0]   quot_q;
    logic [WIDTH-1:0]   rem_q;
    logic               busy_q;
    logic               done_q;
    logic               dbz_q;

    logic [WIDTH:0]     shifted_d;
    logic [WIDTH:0]     trial_d;
    logic               borrow_d;
    logic [WIDTH-1:0]   prem_d;
    logic [WIDTH-1:0]   shreg_d;

    // One restoring step. The partial remainder is always below the divisor,
    // so the shifted value is below 2*divisor; a WIDTH+1 bit subtraction is
    // therefore enough, with bit WIDTH of the difference acting as the borrow.
    always_comb begin
        shifted_d = {prem_q, shreg_q[WIDTH-1]};
        trial_d   = shifted_d - {1'b0, divisor_q};
        borrow_d  = trial_d[WIDTH];
        prem_d    = borrow_d ? shifted_d[WIDTH-1:0] : trial_d[WIDTH-1:0];
        shreg_d   = {shreg_q[WIDTH-2:0], ~borrow_d};
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            prem_q    <= '0;
            shreg_q   <= '0;
            divisor_q <= '0;
            quot_q    <= '0;
            rem_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                RUN: begin
                    prem_q  <= prem_d;
                    shreg_q <= shreg_d;
                    cnt_q   <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        quot_q  <= shreg_d;
                        rem_q   <= prem_d;
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new request, which gives
                    // zero-bubble back-to-back issue out of DONE.
                    if (bus.start) begin
                        divisor_q <= bus.b;
                        dbz_q     <= 1'b0;
                        if (bus.b != '0) begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                            cnt_q   <= CNT_W'(WIDTH);
                            prem_q  <= '0;
                            shreg_q <= bus.a;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            dbz_q   <= 1'b1;
                            quot_q  <= '1;
                            rem_q   <= bus.a;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;

endmodule
`default_nettype wire

// File: tb/tb_div2i2o_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div2i2o_seq
//  Description : Self-checking bench for div2i2o_seq. A countdown/arithmetic
//                model predicts every output each cycle; directed operations
//                pin results, latency and result hold with literal values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_div2i2o_seq;

    localparam int               WIDTH    = 8;
    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    logic clk   = 1'b0;
    logic clr_n = 1'b0;
    logic chk_en = 1'b0;

    div2i2o_seq_if #(.WIDTH(WIDTH)) bus ();

    div2i2o_seq #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [WIDTH-1:0] last_q = '0;
    logic [WIDTH-1:0] last_r = '0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int               m_left;
    logic             m_done;
    logic             m_dbz;
    logic [WIDTH-1:0] m_q, m_r, p_q, p_r;

    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_dbz  <= 1'b0;
            m_q    <= '0;
            m_r    <= '0;
            p_q    <= '0;
            p_r    <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_done <= 1'b1;
                    m_q    <= p_q;
                    m_r    <= p_r;
                end
            end else if (bus.start) begin
                m_dbz <= 1'b0;
                if (bus.b == '0) begin
                    m_done <= 1'b1;
                    m_dbz  <= 1'b1;
                    m_q    <= ALL_ONES;
                    m_r    <= bus.a;
                end else begin
                    m_left <= WIDTH;
                    p_q    <= bus.a / bus.b;
                    p_r    <= bus.a % bus.b;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (clr_n && chk_en) begin
            check("model_busy", {31'b0, bus.busy}, {31'b0, (m_left > 0)});
            check("model_done", {31'b0, bus.done}, {31'b0, m_done});
            check("model_dbz",  {31'b0, bus.div_by_zero}, {31'b0, m_dbz});
            check("model_quot", 32'(bus.quotient), 32'(m_q));
            check("model_rem",  32'(bus.remainder), 32'(m_r));
        end
    end

    // ---------------- directed operation with literal expectations ----------------
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] eq, input logic [WIDTH-1:0] er,
                          input bit imm);
        int k;
        bit got;
        int lat;
        lat = (b == '0) ? 1 : WIDTH + 1;
        if (!imm) @(negedge clk);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        k   = 0;
        got = 0;
        while (!got && k < 4 * WIDTH) begin
            @(negedge clk);
            bus.start = 1'b0;
            k++;
            if (k == 1) begin
                check("busy_after_accept", {31'b0, bus.busy}, {31'b0, (b != '0)});
                check("dbz_after_accept", {31'b0, bus.div_by_zero}, {31'b0, (b == '0)});
                if (b != '0) begin
                    check("hold_quot", 32'(bus.quotient), 32'(last_q));
                    check("hold_rem", 32'(bus.remainder), 32'(last_r));
                end
            end
            if (bus.done) got = 1;
        end
        if (!got) begin
            check("done_timeout", 32'd0, 32'd1);
        end else begin
            check("latency", 32'(k), 32'(lat));
            check("quotient", 32'(bus.quotient), 32'(eq));
            check("remainder", 32'(bus.remainder), 32'(er));
            check("div_by_zero", {31'b0, bus.div_by_zero}, {31'b0, (b == '0)});
        end
        last_q = eq;
        last_r = er;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int ndone;
        bit got;
        logic [WIDTH-1:0] ra, rb;

        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;

        // reset state
        #12;
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_done", {31'b0, bus.done}, 32'd0);
        check("rst_dbz",  {31'b0, bus.div_by_zero}, 32'd0);
        check("rst_quot", 32'(bus.quotient), 32'd0);
        check("rst_rem",  32'(bus.remainder), 32'd0);
        @(negedge clk);
        clr_n  = 1'b1;
        chk_en = 1'b1;

        // basic and boundary cases
        run_op(8'd100, 8'd7,   8'd14,  8'd2, 1'b0);
        run_op(8'd255, 8'd1,   8'd255, 8'd0, 1'b0);
        run_op(8'd5,   8'd9,   8'd0,   8'd5, 1'b0);
        run_op(8'd255, 8'd255, 8'd1,   8'd0, 1'b0);
        run_op(8'd0,   8'd5,   8'd0,   8'd0, 1'b0);
        run_op(8'd42,  8'd42,  8'd1,   8'd0, 1'b0);

        // divide by zero, then a start that clears the flag
        run_op(8'd37, 8'd0, 8'd255, 8'd37, 1'b0);
        run_op(8'd9,  8'd3, 8'd3,   8'd0,  1'b0);

        // start while busy is ignored; operands toggle during RUN
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'd100;
        bus.b     = 8'd7;
        k   = 0;
        got = 0;
        while (!got && k < 4 * WIDTH) begin
            @(negedge clk);
            k++;
            if (k == 3) begin
                bus.start = 1'b1;
                bus.a     = 8'd200;
                bus.b     = 8'd3;
            end else begin
                bus.start = 1'b0;
                bus.a     = WIDTH'($urandom);
                bus.b     = WIDTH'($urandom);
            end
            if (bus.done) got = 1;
        end
        bus.start = 1'b0;
        check("ignored_start_done", {31'b0, got}, 32'd1);
        check("ignored_start_latency", 32'(k), 32'(WIDTH + 1));
        check("ignored_start_quot", 32'(bus.quotient), 32'd14);
        check("ignored_start_rem", 32'(bus.remainder), 32'd2);
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        check("no_second_done", 32'(ndone), 32'd0);
        last_q = 8'd14;
        last_r = 8'd2;

        // back-to-back issue from the DONE cycle
        run_op(8'd100, 8'd7, 8'd14, 8'd2, 1'b0);
        run_op(8'd60,  8'd6, 8'd10, 8'd0, 1'b1);

        // asynchronous reset mid-operation
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'd100;
        bus.b     = 8'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        clr_n = 1'b0;
        #1;
        check("arst_busy", {31'b0, bus.busy}, 32'd0);
        check("arst_done", {31'b0, bus.done}, 32'd0);
        check("arst_quot", 32'(bus.quotient), 32'd0);
        check("arst_rem",  32'(bus.remainder), 32'd0);
        check("arst_dbz",  {31'b0, bus.div_by_zero}, 32'd0);
        last_q = '0;
        last_r = '0;
        @(negedge clk);
        @(negedge clk);
        clr_n = 1'b1;
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        check("no_done_after_reset", 32'(ndone), 32'd0);
        run_op(8'd100, 8'd7, 8'd14, 8'd2, 1'b0);
        run_op(8'd255, 8'd255, 8'd1, 8'd0, 1'b1);

        // randomized operations with arithmetic expectations
        for (int i = 0; i < 120; i++) begin
            ra = WIDTH'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? '0 : WIDTH'($urandom);
            if (rb == '0)
                run_op(ra, rb, ALL_ONES, ra, bit'($urandom_range(0, 1)));
            else
                run_op(ra, rb, ra / rb, ra % rb, bit'($urandom_range(0, 1)));
        end

        // random start noise, checked by the model only
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            bus.start = ($urandom_range(0, 3) == 0);
            bus.a     = WIDTH'($urandom);
            bus.b     = ($urandom_range(0, 7) == 0) ? '0 : WIDTH'($urandom);
        end
        @(negedge clk);
        bus.start = 1'b0;
        repeat (12) @(negedge clk);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/div2i2o_seq.md
Name: div2i2o_seq

Overview:
Sequential unsigned radix-2 restoring divider. It is the inverse-operation companion to the multiplier library: it takes a dividend and a divisor and produces a quotient and a remainder. It computes one quotient bit per clock and uses a start/busy/done handshake. It sits beside the multipliers in math/ for datapaths that need a small-area divide.

Parameters:
WIDTH, 8, operand width in bits; dividend, divisor, quotient and remainder are all WIDTH bits; WIDTH >= 2.

Ports:
clk  input  1  system clock, rising-edge active.
clr_n  input  1  asynchronous active-low reset.
start  input  1  request a new division; sampled on the rising edge of clk; honoured only while busy=0.
a  input  WIDTH  dividend; sampled on the accepting edge only.
b  input  WIDTH  divisor; sampled on the accepting edge only.
busy  output  1  high while a division is in progress (RUN state).
done  output  1  single-cycle pulse; quotient and remainder are valid from this cycle onward.
div_by_zero  output  1  set with done when the captured b was 0; held until the next accepted start.
quotient  output  WIDTH  a / b, registered.
remainder  output  WIDTH  a % b, registered.

Behaviour:
- One clock, clk. Reset clr_n is asynchronous and active-low. All state is held in flops reset by clr_n.
- Reset values:
  - state=IDLE.
  - busy=0, done=0, div_by_zero=0.
  - quotient=0, remainder=0.
  - Internal registers and iteration counter cleared.
- States: IDLE, RUN, DONE. busy = (state==RUN).
- IDLE or DONE with start=1 at edge E0:
  - Capture a and b.
  - If b!=0: go to RUN, load counter=WIDTH, partial remainder=0, shift register=a.
  - If b==0: go directly to DONE.
- RUN, on each edge:
  - Shift {partial remainder, shift register} left by 1.
  - Trial subtract b from the partial remainder, using WIDTH+1 bits so the borrow is kept.
  - If no borrow: keep the difference and shift in quotient bit 1; otherwise restore and shift in 0.
  - Decrement the counter.
  - On the edge where the counter goes 1->0, load quotient and remainder and go to DONE.
- Latency: for b!=0, done is high in the cycle after edge E0+WIDTH (WIDTH RUN cycles); for b==0, done is high in the cycle after E0.
- DONE lasts exactly one cycle; done=1 only in DONE.
  - Next edge: go to IDLE, or to RUN/DONE if start=1 (back-to-back issue, zero bubble).
- Divide by zero:
  - quotient = all ones (2^WIDTH-1), remainder = a.
  - div_by_zero=1 from the DONE cycle until the next accepted start; it is cleared on that accepting edge.
- Result hold: quotient and remainder hold their last values until the next completion. They are not cleared on a new start, and intermediate values are never visible on them.
- start while busy=1 is ignored: no capture, no effect on the operation in flight. a and b may change freely during RUN.
- Arithmetic: unsigned only. Results for every b!=0 must satisfy a = quotient*b + remainder with remainder < b.
- clr_n asserted mid-operation: outputs go to reset values immediately (asynchronously) and the operation is abandoned. After release the block is in IDLE and no done is issued for the abandoned operation.
- Boundary cases, all b!=0, must take the full WIDTH cycles (no early termination): a=0, a<b, a=b, b=1, a=b=2^WIDTH-1.

Test Plan:
- WIDTH=8, start with a=100, b=7 -> busy for 8 cycles, done pulse 1 cycle, quotient=14, remainder=2, div_by_zero=0.
- a=255,b=1 -> q=255,r=0; a=5,b=9 -> q=0,r=5; a=255,b=255 -> q=1,r=0. Each done arrives exactly 8 cycles after acceptance.
- a=37, b=0 -> done in the cycle after acceptance, q=255, r=37, div_by_zero=1. A following start with a=9, b=3 clears div_by_zero on acceptance and ends with q=3, r=0.
- Pulse start with a=200, b=3 three cycles into the 100/7 op, with a and b toggling during RUN -> ignored; the result is still 14/2, and no second done is issued.
- Hold start=1 in the DONE cycle with a=60, b=6 -> the second op is accepted with no idle gap and ends with q=10, r=0. Across the gap, 14/2 stays on the outputs until the new done.
- Assert clr_n low at RUN cycle 4 -> busy, done, quotient and remainder go to 0 immediately. After release, no spurious done; a fresh 100/7 gives 14/2.
